// File: rtl/melody_player_if.sv
// Control and note bus between the tune sequencer and its neighbours.
// The host drives play/stop/loop. The sequencer drives the note bus and the status outputs.
interface melody_player_if;
    logic       play;
    logic       stop;
    logic       loop;
    logic [7:0] note;
    logic       busy;
    logic       done;
    logic [3:0] addr;

    modport master (output play, stop, loop, input note, busy, done, addr);
    modport slave  (input play, stop, loop, output note, busy, done, addr);
endinterface

// File: rtl/melody_player.sv
// Fixed-table tune sequencer: plays one-hot notes for dur*TICK_DIV cycles each.
// A GAP_CYCLES silence follows every note. All outputs come straight from registers.
module melody_player #(
    parameter int TICK_DIV   = 62500,
    parameter int GAP_CYCLES = 5000
) (
    input logic             clk,
    input logic             rst,
    melody_player_if.slave  bus
);
    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [GW-1:0] GAP_LAST  = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_PLAY, S_GAP} state_t;

    state_t        state_q;
    logic [7:0]    note_q, lnote_q;
    logic          busy_q, done_q;
    logic [3:0]    addr_q, dur_q, unit_q;
    logic [TW-1:0] tick_q;
    logic [GW-1:0] gap_q;

    logic [7:0]    rom_w, ent_note;
    logic [3:0]    code_w, ent_dur, unit_d, addr_d;
    logic          ent_end;
    logic [TW-1:0] tick_d;
    logic [GW-1:0] gap_d;

    // Each table word is {code, duration}: C C G G A A G F F E E D D C, then end markers.
    always_comb begin
        rom_w = 8'hF0;
        case (addr_q)
            4'd0:  rom_w = 8'h12;
            4'd1:  rom_w = 8'h12;
            4'd2:  rom_w = 8'h52;
            4'd3:  rom_w = 8'h52;
            4'd4:  rom_w = 8'h62;
            4'd5:  rom_w = 8'h62;
            4'd6:  rom_w = 8'h54;
            4'd7:  rom_w = 8'h42;
            4'd8:  rom_w = 8'h42;
            4'd9:  rom_w = 8'h32;
            4'd10: rom_w = 8'h32;
            4'd11: rom_w = 8'h22;
            4'd12: rom_w = 8'h22;
            4'd13: rom_w = 8'h14;
            default: rom_w = 8'hF0;
        endcase
    end

    always_comb begin
        code_w   = rom_w[7:4];
        ent_end  = (code_w == 4'd15);
        ent_dur  = (rom_w[3:0] == 4'd0) ? 4'd1 : rom_w[3:0];
        ent_note = 8'd0;
        if (code_w >= 4'd1 && code_w <= 4'd8)
            ent_note = 8'b1 << (code_w - 4'd1);
        unit_d = unit_q + 4'd1;
        tick_d = tick_q + 1'b1;
        gap_d  = gap_q + 1'b1;
        addr_d = addr_q + 4'd1;
    end

    always_ff @(posedge clk) begin
        if (rst || bus.stop) begin
            state_q <= S_IDLE;
            note_q  <= 8'd0;
            lnote_q <= 8'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            addr_q  <= 4'd0;
            dur_q   <= 4'd0;
            unit_q  <= 4'd0;
            tick_q  <= '0;
            gap_q   <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.play) begin
                        addr_q  <= 4'd0;
                        busy_q  <= 1'b1;
                        state_q <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (ent_end) begin
                        if (bus.loop) begin
                            addr_q <= 4'd0;
                        end else begin
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= S_IDLE;
                        end
                    end else begin
                        lnote_q <= ent_note;
                        note_q  <= ent_note;
                        dur_q   <= ent_dur;
                        unit_q  <= 4'd0;
                        tick_q  <= '0;
                        state_q <= S_PLAY;
                    end
                end
                S_PLAY: begin
                    if (tick_q == TICK_LAST) begin
                        tick_q <= '0;
                        unit_q <= unit_d;
                        if (unit_d == dur_q) begin
                            note_q <= 8'd0;
                            unit_q <= 4'd0;
                            gap_q  <= '0;
                            if (GAP_CYCLES == 0) begin
                                addr_q  <= addr_d;
                                state_q <= S_LOAD;
                            end else begin
                                state_q <= S_GAP;
                            end
                        end
                    end else begin
                        tick_q <= tick_d;
                    end
                end
                S_GAP: begin
                    if (gap_q == GAP_LAST) begin
                        gap_q   <= '0;
                        addr_q  <= addr_d;
                        state_q <= S_LOAD;
                    end else begin
                        gap_q <= gap_d;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.note = note_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.addr = addr_q;
endmodule

// File: tb/tb_melody_player.sv
// Directed bench for melody_player with TICK_DIV=4 and GAP_CYCLES=2.
// Outputs are sampled on the falling edge. Inputs change right after each sample.
module tb_melody_player;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_fail = 0;
    int   busy_cyc = 0;
    int   done_cnt = 0;

    melody_player_if bus ();

    melody_player #(.TICK_DIV(4), .GAP_CYCLES(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.busy) busy_cyc = busy_cyc + 1;
        if (bus.done) done_cnt = done_cnt + 1;
    end

    logic [7:0] NOTE [14] = '{8'h01, 8'h01, 8'h10, 8'h10, 8'h20, 8'h20, 8'h10,
                              8'h08, 8'h08, 8'h04, 8'h04, 8'h02, 8'h02, 8'h01};
    int         DUR  [14] = '{2, 2, 2, 2, 2, 2, 4, 2, 2, 2, 2, 2, 2, 4};

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    // Pulse play for one cycle and check the LOAD cycle that follows.
    task automatic start();
        bus.play = 1'b1;
        @(negedge clk);
        bus.play = 1'b0;
        chk("load_busy", int'(bus.busy), 1);
        chk("load_note", int'(bus.note), 0);
        chk("load_addr", int'(bus.addr), 0);
    endtask

    // Check cycle by cycle from the first note cycle of index 0 through the LOAD after index n-1.
    task automatic follow(input int n, input bit poke);
        for (int i = 0; i < n; i++) begin
            for (int c = 0; c < DUR[i] * 4; c++) begin
                @(negedge clk);
                chk($sformatf("note[%0d]", i), int'(bus.note), int'(NOTE[i]));
                chk($sformatf("addr[%0d]", i), int'(bus.addr), i);
                chk($sformatf("busy[%0d]", i), int'(bus.busy), 1);
                chk($sformatf("done[%0d]", i), int'(bus.done), 0);
                bus.play = poke && (c == 2);
            end
            for (int g = 0; g < 3; g++) begin
                @(negedge clk);
                bus.play = 1'b0;
                chk($sformatf("gap_note[%0d]", i), int'(bus.note), 0);
                chk($sformatf("gap_busy[%0d]", i), int'(bus.busy), 1);
                chk($sformatf("gap_addr[%0d]", i), int'(bus.addr), (g == 2) ? i + 1 : i);
            end
        end
    endtask

    initial begin
        int b0, d0;
        bus.play = 1'b0;
        bus.stop = 1'b0;
        bus.loop = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_note", int'(bus.note), 0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_done", int'(bus.done), 0);
        chk("rst_addr", int'(bus.addr), 0);

        // Single start: the first two notes and the silence between them.
        start();
        follow(2, 1'b0);
        // Reset in the middle of index 2.
        repeat (3) @(negedge clk);
        chk("mid_note", int'(bus.note), 8'h10);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst2_note", int'(bus.note), 0);
        chk("rst2_busy", int'(bus.busy), 0);
        chk("rst2_done", int'(bus.done), 0);
        chk("rst2_addr", int'(bus.addr), 0);

        // Full song with loop=0. Play pokes during PLAY must be ignored.
        b0 = busy_cyc;
        d0 = done_cnt;
        start();
        follow(14, 1'b1);
        @(negedge clk);
        chk("end_done", int'(bus.done), 1);
        chk("end_busy", int'(bus.busy), 0);
        chk("end_note", int'(bus.note), 0);
        @(negedge clk);
        chk("end_done_clr", int'(bus.done), 0);
        chk("song_busy_cycles", busy_cyc - b0, 171);
        chk("song_done_count", done_cnt - d0, 1);

        // Stop on the 5th cycle of index 3.
        d0 = done_cnt;
        start();
        follow(3, 1'b0);
        repeat (5) @(negedge clk);
        chk("pre_stop_note", int'(bus.note), 8'h10);
        chk("pre_stop_addr", int'(bus.addr), 3);
        bus.stop = 1'b1;
        @(negedge clk);
        bus.stop = 1'b0;
        chk("stop_note", int'(bus.note), 0);
        chk("stop_busy", int'(bus.busy), 0);
        chk("stop_addr", int'(bus.addr), 0);
        chk("stop_done", int'(bus.done), 0);
        repeat (3) @(negedge clk);
        chk("stop_idle", int'(bus.busy), 0);
        chk("stop_no_done", done_cnt - d0, 0);
        start();
        @(negedge clk);
        chk("restart_note", int'(bus.note), 8'h01);
        chk("restart_addr", int'(bus.addr), 0);
        bus.stop = 1'b1;
        @(negedge clk);
        bus.stop = 1'b0;
        chk("stop2_busy", int'(bus.busy), 0);

        // Loop: first pass, one reload cycle, then a second pass that ends normally.
        d0 = done_cnt;
        bus.loop = 1'b1;
        start();
        follow(14, 1'b0);
        @(negedge clk);
        chk("loop_note", int'(bus.note), 0);
        chk("loop_busy", int'(bus.busy), 1);
        chk("loop_addr", int'(bus.addr), 0);
        chk("loop_done", int'(bus.done), 0);
        bus.loop = 1'b0;
        follow(14, 1'b0);
        @(negedge clk);
        chk("loop_end_done", int'(bus.done), 1);
        chk("loop_end_busy", int'(bus.busy), 0);
        @(negedge clk);
        chk("loop_done_count", done_cnt - d0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
